// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and framing constants for the instruction memory loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        DONE,
        ERR
    } ldr_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - gathers accepted bytes little-endian into 32-bit words
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [23:0]      shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            // Newest byte enters at the top so the first byte ends up in bits [7:0]
            shift_d = {byte_data, shift_q[23:8]};
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign word       = {byte_data, shift_q};
    assign word_valid = byte_valid && !clear && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream boot loader for the instruction memory
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    ldr_state_t        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [15:0]       words_q, words_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       len_rx;
    logic              packer_clear;
    logic [31:0]       packed_word;
    logic              packed_valid;

    assign xfer   = in_valid && in_ready_q;
    assign len_rx = {in_data, len_lo_q};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_valid (xfer && (state_q == DATA)),
        .byte_data  (in_data),
        .word       (packed_word),
        .word_valid (packed_valid)
    );

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        checksum_d   = checksum_q;
        words_d      = words_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        packer_clear = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = LEN0;
                    words_d      = '0;
                    checksum_d   = '0;
                    packer_clear = 1'b1;
                end
            end
            LEN0: begin
                if (xfer) begin
                    len_lo_d   = in_data;
                    checksum_d = checksum_q + in_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    len_d      = len_rx;
                    checksum_d = checksum_q + in_data;
                    if ({1'b0, len_rx} > MAX_LEN) begin
                        state_d = ERR;
                    end else if (len_rx == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    checksum_d = checksum_q + in_data;
                    if (packed_valid) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = words_q[ADDR_W-1:0];
                        imem_wdata_d = packed_word;
                        words_d      = words_q + 16'd1;
                        // Leaving now lets the byte in the write cycle count as the checksum
                        if (words_d == len_q) begin
                            state_d = CHK;
                        end
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    state_d = (in_data == checksum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                     (state_d == DATA) || (state_d == CHK);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        hold_d     = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            checksum_q   <= '0;
            words_q      <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            checksum_q   <= checksum_d;
            words_q      <= words_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign core_rst_hold = hold_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] frame_w[$];

    imem_loader #(.ADDR_W(8), .DATA_W(32), .MAX_WORDS(256)) dut (
        .clk           (clk),
        .rst           (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .core_rst_hold (core_rst_hold),
        .done          (done),
        .err           (err),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected write, one cycle after its 4th byte
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_hold"}, 32'(core_rst_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit push,
                             input logic [7:0] addr, input logic [31:0] data);
        int n;
        wr_t e;
        if (gap) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = b;
        if (push) begin
            e.addr = addr;
            e.data = data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int chk_adj, input bit gap, input bit mid_start);
        logic [7:0]  sum;
        logic [15:0] n;
        logic [31:0] w;
        n   = 16'(frame_w.size());
        sum = n[7:0] + n[15:8];
        send_byte(n[7:0], gap, 1'b0, 8'h00, 32'h0);
        send_byte(n[15:8], gap, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < frame_w.size(); i++) begin
            w = frame_w[i];
            if (mid_start && i == 1) begin
                pulse_start();
            end
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[8*b +: 8];
                send_byte(w[8*b +: 8], gap, b == 3, 8'(i), w);
            end
        end
        send_byte(sum + 8'(chk_adj), gap, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic check_done(input string tag, input logic [15:0] n);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_hold"}, 32'(core_rst_hold), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(n));
    endtask

    task automatic check_err(input string tag, input logic [15:0] n);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_hold"}, 32'(core_rst_hold), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(n));
    endtask

    initial begin
        // Reset, then idle with no start
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_outputs("idle");

        // Two-word load
        frame_w = '{32'h0000_0013, 32'h0010_0093};
        pulse_start();
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_hold", 32'(core_rst_hold), 32'd1);
        send_frame(0, 1'b0, 1'b0);
        check_done("two_word", 16'd2);
        repeat (3) @(negedge clk);
        check("done_level", 32'(done), 32'd1);

        // Restart from DONE, bad checksum
        pulse_start();
        check("restart_done_clear", 32'(done), 32'd0);
        check("restart_hold", 32'(core_rst_hold), 32'd1);
        check("restart_words", 32'(words_loaded), 32'd0);
        send_frame(1, 1'b0, 1'b0);
        check_err("bad_chk", 16'd2);
        repeat (3) @(negedge clk);
        check("err_level", 32'(err), 32'd1);

        // Oversize image: error right after len_hi, no writes
        pulse_start();
        check("err_exit", 32'(err), 32'd0);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00, 32'h0);
        check_err("oversize", 16'd0);

        // Largest accepted length passes the size check
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00, 32'h0);
        check("max_len_err", 32'(err), 32'd0);
        check("max_len_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty image
        frame_w = {};
        pulse_start();
        send_frame(0, 1'b0, 1'b0);
        check_done("empty", 16'd0);

        // Gaps on in_valid plus an ignored start mid-frame
        frame_w = '{32'h0000_0013, 32'h0010_0093};
        pulse_start();
        send_frame(0, 1'b1, 1'b1);
        check_done("gaps", 16'd2);

        // Three random words with gaps
        frame_w = '{$urandom(), $urandom(), $urandom()};
        pulse_start();
        send_frame(0, 1'b1, 1'b0);
        check_done("random3", 16'd3);

        // Reset in the middle of DATA
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h13, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h00, 1'b0, 1'b1, 8'h00, 32'h0000_0013);
        send_byte(8'h93, 1'b0, 1'b0, 8'h00, 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("post_reset");
        frame_w = '{32'hDEAD_BEEF, 32'h0010_0093};
        pulse_start();
        send_frame(0, 1'b0, 1'b0);
        check_done("reload", 16'd2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
